bcd_updown_counter: RTL and testbench

Parametrised multi-digit BCD counter, successor to the 4-bit single-digit T-flip-flop BCD counter. It counts up or down across `DIGITS` packed decimal digits with a correct ripple between digits. It also adds synchronous load, count enable, wrap/saturate mode, a registered carry/borrow pulse and a limit flag. It drives display and timer logic that cascades decimal counters.

---
 rtl/bcd_updown_counter.sv | 116 +++++++++++
 tb/tb_bcd_updown_counter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_updown_counter
// Brief    : Multi-digit packed BCD up/down counter with synchronous load,
//            count enable, wrap/saturate mode, registered carry/borrow pulse
//            and a combinational limit flag.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_updown_counter #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  clear,
   input  logic                  en,
   input  logic                  up,
   input  logic                  sat,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_value,
   output logic [4*DIGITS-1:0]   count,
   output logic                  carry,
   output logic                  at_limit
);

   localparam logic [3:0] C_NINE = 4'd9;
   localparam logic [3:0] C_ZERO = 4'd0;
   localparam logic [3:0] C_ONE  = 4'd1;

   logic [4*DIGITS-1:0] count_q, count_d;
   logic                carry_q, carry_d;

   // Load data with every digit above 9 clamped to 9.
   logic [4*DIGITS-1:0] load_clamped;

   // Candidate next values for an up step and a down step.
   logic [4*DIGITS-1:0] inc_value;
   logic [4*DIGITS-1:0] dec_value;
   logic                all_nine;
   logic                all_zero;

   // Per-digit clamp of the load data so no illegal BCD digit can be stored.
   for (genvar k = 0; k < DIGITS; k++) begin : g_clamp
      assign load_clamped[4*k +: 4] = (load_value[4*k +: 4] > C_NINE) ?
                                      C_NINE : load_value[4*k +: 4];
   end

   // Ripple logic: a digit moves only when all lower digits sit at their limit.
   always_comb begin
      logic       lower_nine;
      logic       lower_zero;
      logic [3:0] dig;
      inc_value  = count_q;
      dec_value  = count_q;
      lower_nine = 1'b1;
      lower_zero = 1'b1;
      dig        = C_ZERO;
      for (int k = 0; k < DIGITS; k++) begin
         dig = count_q[4*k +: 4];
         if (lower_nine) begin
            inc_value[4*k +: 4] = (dig == C_NINE) ? C_ZERO : dig + C_ONE;
         end
         if (lower_zero) begin
            dec_value[4*k +: 4] = (dig == C_ZERO) ? C_NINE : dig - C_ONE;
         end
         lower_nine = lower_nine & (dig == C_NINE);
         lower_zero = lower_zero & (dig == C_ZERO);
      end
      all_nine = lower_nine;
      all_zero = lower_zero;
   end

   // Next-state selection: load beats enable; saturate holds at the limit.
   always_comb begin
      count_d = count_q;
      carry_d = 1'b0;
      if (load) begin
         count_d = load_clamped;
      end else if (en) begin
         if (up) begin
            if (all_nine) begin
               if (!sat) begin
                  count_d = inc_value;
                  carry_d = 1'b1;
               end
            end else begin
               count_d = inc_value;
            end
         end else begin
            if (all_zero) begin
               if (!sat) begin
                  count_d = dec_value;
                  carry_d = 1'b1;
               end
            end else begin
               count_d = dec_value;
            end
         end
      end
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         count_q <= '0;
         carry_q <= 1'b0;
      end else begin
         count_q <= count_d;
         carry_q <= carry_d;
      end
   end

   assign count    = count_q;
   assign carry    = carry_q;
   assign at_limit = up ? all_nine : all_zero;

endmodule
`default_nettype wire

// File: tb/tb_bcd_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_updown_counter
// Brief    : Directed self-checking bench for bcd_updown_counter (DIGITS=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_updown_counter;

   localparam int DIGITS = 4;

   logic                clk;
   logic                clear;
   logic                en;
   logic                up;
   logic                sat;
   logic                load;
   logic [4*DIGITS-1:0] load_value;
   logic [4*DIGITS-1:0] count;
   logic                carry;
   logic                at_limit;

   int n_cmp;
   int n_err;

   bcd_updown_counter #(.DIGITS(DIGITS)) dut (
      .clk        (clk),
      .clear      (clear),
      .en         (en),
      .up         (up),
      .sat        (sat),
      .load       (load),
      .load_value (load_value),
      .count      (count),
      .carry      (carry),
      .at_limit   (at_limit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_load(input logic [15:0] v);
      load       = 1'b1;
      en         = 1'b0;
      load_value = v;
      tick();
      load       = 1'b0;
   endtask

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      clear      = 1'b0;
      en         = 1'b0;
      up         = 1'b0;
      sat        = 1'b0;
      load       = 1'b0;
      load_value = '0;

      // Reset state
      #12;
      check("rst_count", 32'(count), 32'h0000);
      check("rst_carry", 32'(carry), 32'h0);
      check("rst_limit_dn", 32'(at_limit), 32'h1);
      up = 1'b1;
      #1;
      check("rst_limit_up", 32'(at_limit), 32'h0);

      // Release and count three steps
      clear = 1'b1;
      en    = 1'b1;
      tick(); tick(); tick();
      check("first_steps", 32'(count), 32'h0003);
      check("first_carry", 32'(carry), 32'h0);

      // Ripple up
      do_load(16'h0099);
      check("load_0099", 32'(count), 32'h0099);
      en = 1'b1; up = 1'b1;
      tick();
      check("ripple_0100", 32'(count), 32'h0100);
      check("ripple_carry", 32'(carry), 32'h0);
      do_load(16'h0999);
      en = 1'b1;
      tick();
      check("ripple_1000", 32'(count), 32'h1000);

      // Ripple down
      do_load(16'h1000);
      en = 1'b1; up = 1'b0;
      tick();
      check("ripple_dn_0999", 32'(count), 32'h0999);

      // Wrap up
      up = 1'b1;
      do_load(16'h9999);
      check("limit_9999_up", 32'(at_limit), 32'h1);
      en = 1'b1;
      tick();
      check("wrap_up_count", 32'(count), 32'h0000);
      check("wrap_up_carry", 32'(carry), 32'h1);
      en = 1'b0;
      tick();
      check("wrap_up_pulse_end", 32'(carry), 32'h0);
      check("hold_count", 32'(count), 32'h0000);

      // Wrap down
      up = 1'b0; en = 1'b1;
      tick();
      check("wrap_dn_count", 32'(count), 32'h9999);
      check("wrap_dn_carry", 32'(carry), 32'h1);
      tick();
      check("dn_after_wrap", 32'(count), 32'h9998);
      check("dn_carry_end", 32'(carry), 32'h0);

      // Saturate down at zero
      sat = 1'b1;
      do_load(16'h0000);
      en = 1'b1; up = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("sat_dn_count", 32'(count), 32'h0000);
         check("sat_dn_carry", 32'(carry), 32'h0);
      end
      check("sat_dn_limit", 32'(at_limit), 32'h1);
      up = 1'b1;
      #1;
      check("sat_up_limit", 32'(at_limit), 32'h0);
      tick();
      check("sat_up_step", 32'(count), 32'h0001);

      // Saturate up at all nines
      do_load(16'h9999);
      en = 1'b1;
      tick();
      check("sat_up_hold", 32'(count), 32'h9999);
      check("sat_up_carry", 32'(carry), 32'h0);

      // Load priority over enable, with clamp
      sat        = 1'b0;
      load       = 1'b1;
      en         = 1'b1;
      load_value = 16'h1AF3;
      tick();
      load = 1'b0;
      en   = 1'b0;
      check("load_clamp", 32'(count), 32'h1993);
      check("load_carry", 32'(carry), 32'h0);
      do_load(16'hFFFF);
      check("load_clamp_all", 32'(count), 32'h9999);

      // Asynchronous clear mid-count
      do_load(16'h0457);
      en = 1'b1; up = 1'b1;
      #1;
      clear = 1'b0;
      #1;
      check("async_clear", 32'(count), 32'h0000);
      check("async_carry", 32'(carry), 32'h0);
      #1;
      clear = 1'b1;
      tick();
      check("after_clear", 32'(count), 32'h0001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
